// File: rtl/rf_writeback_scheduler.sv
// Arbitrates NUM_WB writeback requesters onto the single scalar register-file write port and
// keeps a per-register pending-write scoreboard that gates issue on RAW/WAW hazards.
module rf_writeback_scheduler #(
  parameter int SCALAR_REGS = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_WB      = 3,
  parameter int AW          = $clog2(SCALAR_REGS),
  parameter int IW          = $clog2(NUM_WB)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iss_valid,
  input  logic                         iss_rd_en,
  input  logic [AW-1:0]                iss_rd_addr,
  input  logic [AW-1:0]                iss_rs1_addr,
  input  logic [AW-1:0]                iss_rs2_addr,
  output logic                         iss_ready,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*AW-1:0]         wb_addr,
  input  logic [NUM_WB*DATA_WIDTH-1:0] wb_data,
  output logic [NUM_WB-1:0]            wb_ready,
  output logic                         s_write_enable,
  output logic [AW-1:0]                s_write_reg_addr,
  output logic [DATA_WIDTH-1:0]        s_write_data,
  output logic [SCALAR_REGS-1:0]       busy_mask,
  output logic                         err_unreserved
);

  logic [SCALAR_REGS-1:0] r_busy;
  logic [IW-1:0]          r_ptr;
  logic                   r_we;
  logic [AW-1:0]          r_waddr;
  logic [DATA_WIDTH-1:0]  r_wdata;

  logic                   w_gnt_any;
  logic [IW-1:0]          w_gnt_idx;
  logic [IW:0]            w_sum;
  logic [IW-1:0]          w_cand;
  logic [AW-1:0]          w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic [SCALAR_REGS-1:0] w_set;
  logic [SCALAR_REGS-1:0] w_clr;
  logic [IW-1:0]          w_ptr_nxt;

  // Round-robin search starting at r_ptr, wrapping modulo NUM_WB.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_WB)) begin
        w_sum = w_sum - (IW+1)'(NUM_WB);
      end
      w_cand = w_sum[IW-1:0];
      if (!w_gnt_any && wb_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    wb_ready   = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (w_gnt_any && (w_gnt_idx == IW'(i))) begin
        wb_ready[i] = 1'b1;
        w_sel_addr  = wb_addr[i*AW +: AW];
        w_sel_data  = wb_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_gnt_any) begin
      w_ptr_nxt = (w_gnt_idx == IW'(NUM_WB-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // A set and a clear landing on the same register resolve in favour of the set.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_valid && iss_ready && iss_rd_en) begin
      w_set[iss_rd_addr] = 1'b1;
    end
    if (r_we) begin
      w_clr[r_waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_ptr  <= w_ptr_nxt;
      r_we   <= w_gnt_any;
      if (w_gnt_any) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign iss_ready        = !r_busy[iss_rs1_addr] && !r_busy[iss_rs2_addr] &&
                            !(iss_rd_en && r_busy[iss_rd_addr]);
  assign s_write_enable   = r_we;
  assign s_write_reg_addr = r_waddr;
  assign s_write_data     = r_wdata;
  assign busy_mask        = r_busy;
  assign err_unreserved   = r_we && !r_busy[r_waddr];

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Bench for rf_writeback_scheduler: a reference model pushes expected writes on every grant and
// pops them when the write port fires; directed sequences add fixed expectations on top.
module tb_rf_writeback_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid = 1'b0;
  logic        iss_rd_en = 1'b0;
  logic [4:0]  iss_rd_addr = '0;
  logic [4:0]  iss_rs1_addr = '0;
  logic [4:0]  iss_rs2_addr = '0;
  logic        iss_ready;
  logic [2:0]  wb_valid = '0;
  logic [14:0] wb_addr = '0;
  logic [47:0] wb_data = '0;
  logic [2:0]  wb_ready;
  logic        s_write_enable;
  logic [4:0]  s_write_reg_addr;
  logic [15:0] s_write_data;
  logic [31:0] busy_mask;
  logic        err_unreserved;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] m_busy = '0;
  int          m_ptr = 0;
  logic        chk_vld = 1'b0;
  logic [4:0]  chk_addr = '0;

  rf_writeback_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .iss_valid        (iss_valid),
    .iss_rd_en        (iss_rd_en),
    .iss_rd_addr      (iss_rd_addr),
    .iss_rs1_addr     (iss_rs1_addr),
    .iss_rs2_addr     (iss_rs2_addr),
    .iss_ready        (iss_ready),
    .wb_valid         (wb_valid),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .wb_ready         (wb_ready),
    .s_write_enable   (s_write_enable),
    .s_write_reg_addr (s_write_reg_addr),
    .s_write_data     (s_write_data),
    .busy_mask        (busy_mask),
    .err_unreserved   (err_unreserved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return !m_busy[iss_rs1_addr] && !m_busy[iss_rs2_addr] &&
           !(iss_rd_en && m_busy[iss_rd_addr]);
  endfunction

  function automatic int m_grant();
    int g;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (g < 0 && wb_valid[idx]) g = idx;
    end
    return g;
  endfunction

  // Reference model state advance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '0;
      m_ptr  <= 0;
      exp_q.delete();
    end else begin : mdl
      int          g;
      logic [31:0] nb;
      g = m_grant();
      if (g >= 0) begin
        exp_q.push_back({wb_addr[g*5 +: 5], wb_data[g*16 +: 16]});
        m_ptr <= (g + 1) % 3;
      end
      nb = m_busy;
      if (chk_vld) nb[chk_addr] = 1'b0;
      if (iss_valid && iss_rd_en && m_ready()) nb[iss_rd_addr] = 1'b1;
      m_busy <= nb;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_vld <= 1'b0;
    end else begin : cmp
      int   g;
      logic [2:0] exp_rdy;
      wr_t  e;
      g = m_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("mdl_wb_ready", wb_ready, exp_rdy);
      chk("mdl_iss_ready", iss_ready, m_ready());
      chk("mdl_busy_mask", busy_mask, m_busy);
      chk("mdl_we", s_write_enable, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mdl_waddr", s_write_reg_addr, e.addr);
        chk("mdl_wdata", s_write_data, e.data);
        chk("mdl_err", err_unreserved, !m_busy[e.addr]);
        chk_vld  <= 1'b1;
        chk_addr <= e.addr;
      end else begin
        chk("mdl_err_idle", err_unreserved, 1'b0);
        chk_vld <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_wb(input int i, input logic [4:0] a, input logic [15:0] d);
    wb_addr[i*5 +: 5]   = a;
    wb_data[i*16 +: 16] = d;
  endtask

  task automatic set_iss(input logic v, input logic en, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
    iss_valid    = v;
    iss_rd_en    = en;
    iss_rd_addr  = rd;
    iss_rs1_addr = rs1;
    iss_rs2_addr = rs2;
  endtask

  logic [2:0] rr_exp [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                             3'b001, 3'b100, 3'b001};

  initial begin
    // T1: reset mid-operation with everything active
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    set_iss(1'b1, 1'b1, 5'd10, 5'd11, 5'd12);
    wb_valid = 3'b111;
    set_wb(0, 5'd20, 16'h1111);
    set_wb(1, 5'd21, 16'h2222);
    set_wb(2, 5'd22, 16'h3333);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_busy_rst", busy_mask, 32'h0);
    chk("t1_we_rst", s_write_enable, 1'b0);
    chk("t1_err_rst", err_unreserved, 1'b0);
    tick();
    rst_n = 1'b1;
    set_iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    smp();
    chk("t1_first_grant", wb_ready, 3'b001);
    tick();
    wb_valid = 3'b000;
    tick(); tick();

    // T2: reserve r5, write it back, see it clear
    set_iss(1'b1, 1'b1, 5'd5, 5'd1, 5'd2);
    smp();
    chk("t2_iss_ready", iss_ready, 1'b1);
    tick();
    set_iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    smp();
    chk("t2_busy5_set", busy_mask[5], 1'b1);
    tick();
    wb_valid = 3'b001;
    set_wb(0, 5'd5, 16'h1234);
    smp();
    chk("t2_grant0", wb_ready, 3'b001);
    tick();
    wb_valid = 3'b000;
    smp();
    chk("t2_we", s_write_enable, 1'b1);
    chk("t2_addr", s_write_reg_addr, 5'd5);
    chk("t2_data", s_write_data, 16'h1234);
    chk("t2_err", err_unreserved, 1'b0);
    chk("t2_busy5_held", busy_mask[5], 1'b1);
    tick();
    smp();
    chk("t2_busy5_clr", busy_mask[5], 1'b0);
    chk("t2_we_off", s_write_enable, 1'b0);

    // T3: RAW stall on r7
    tick();
    set_iss(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    set_iss(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
    wb_valid = 3'b100;
    set_wb(2, 5'd7, 16'hBEEF);
    smp();
    chk("t3_stall", iss_ready, 1'b0);
    tick();
    wb_valid = 3'b000;
    smp();
    chk("t3_we", s_write_enable, 1'b1);
    chk("t3_stall_during_we", iss_ready, 1'b0);
    tick();
    smp();
    chk("t3_ready_rise", iss_ready, 1'b1);
    chk("t3_busy7_clr", busy_mask[7], 1'b0);
    tick();
    set_iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();

    // T4: round-robin, all three then 0 and 2
    wb_valid = 3'b111;
    set_wb(0, 5'd20, 16'h0A0A);
    set_wb(1, 5'd21, 16'h0B0B);
    set_wb(2, 5'd22, 16'h0C0C);
    for (int k = 0; k < 9; k++) begin
      smp();
      chk($sformatf("t4_rr%0d", k), wb_ready, rr_exp[k]);
      tick();
      if (k == 5) wb_valid = 3'b101;
    end
    wb_valid = 3'b000;
    tick(); tick();

    // T5: back-to-back writes from requesters 1 and 2
    set_iss(1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    set_iss(1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    set_iss(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    wb_valid = 3'b010;
    set_wb(1, 5'd3, 16'hAAAA);
    smp();
    chk("t5_busy34", busy_mask[4:3], 2'b11);
    tick();
    wb_valid = 3'b100;
    set_wb(2, 5'd4, 16'h5555);
    smp();
    chk("t5_we_a", s_write_enable, 1'b1);
    chk("t5_addr_a", s_write_reg_addr, 5'd3);
    chk("t5_data_a", s_write_data, 16'hAAAA);
    tick();
    wb_valid = 3'b000;
    smp();
    chk("t5_we_b", s_write_enable, 1'b1);
    chk("t5_addr_b", s_write_reg_addr, 5'd4);
    chk("t5_data_b", s_write_data, 16'h5555);
    chk("t5_busy34_mid", busy_mask[4:3], 2'b10);
    tick();
    smp();
    chk("t5_busy34_clr", busy_mask[4:3], 2'b00);
    chk("t5_we_off", s_write_enable, 1'b0);

    // T6: write to a register that was never reserved
    chk("t6_busy_zero", busy_mask, 32'h0);
    tick();
    wb_valid = 3'b010;
    set_wb(1, 5'd9, 16'h0909);
    tick();
    wb_valid = 3'b000;
    smp();
    chk("t6_we", s_write_enable, 1'b1);
    chk("t6_addr", s_write_reg_addr, 5'd9);
    chk("t6_data", s_write_data, 16'h0909);
    chk("t6_err_pulse", err_unreserved, 1'b1);
    tick();
    smp();
    chk("t6_err_drop", err_unreserved, 1'b0);
    chk("t6_we_off", s_write_enable, 1'b0);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
